// File: rtl/multicycle_ctrl_pkg.sv
// multicycle_ctrl_pkg: shared ALU codes, opcode/funct constants and controller state type
package multicycle_ctrl_pkg;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  typedef enum logic [3:0] {
    FETCH, DECODE, RTYPE, ALUWB, MEMADR, MEMRD, MEMWB, MEMWR,
    BRANCH, ADDIEX, ADDIWB, JUMP, ILLEGAL
  } ctrl_state_t;
endpackage

// File: rtl/multicycle_ctrl_alu_dec.sv
// multicycle_ctrl_alu_dec: R-type funct -> {aluctr, valid}
module multicycle_ctrl_alu_dec
  import multicycle_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [1:0] aluctr,
  output logic       valid
);
  always_comb begin
    aluctr = funct == FN_SUB ? ALU_SUB : funct == FN_AND ? ALU_AND : funct == FN_OR ? ALU_OR : ALU_ADD;
    valid  = funct == FN_ADD || funct == FN_SUB || funct == FN_AND || funct == FN_OR;
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle datapath control FSM (IR/zero/mem_ready in; memory, PC, regfile and ALU controls out)
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       reg_we,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] aluctr,
  output logic       illegal
);
  ctrl_state_t state, nxt;
  logic [1:0] fn_aluctr;
  logic fn_valid;
  multicycle_ctrl_alu_dec alu_dec (.funct(funct), .aluctr(fn_aluctr), .valid(fn_valid));
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= FETCH;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      FETCH:  nxt = mem_ready ? DECODE : FETCH;
      DECODE:
        case (opcode)
          OP_RTYPE:     nxt = RTYPE;
          OP_LW, OP_SW: nxt = MEMADR;
          OP_BEQ:       nxt = BRANCH;
          OP_ADDI:      nxt = ADDIEX;
          OP_J:         nxt = JUMP;
          default:      nxt = ILLEGAL;
        endcase
      RTYPE:  nxt = fn_valid ? ALUWB : ILLEGAL;
      MEMADR: nxt = opcode == OP_SW ? MEMWR : MEMRD;
      MEMRD:  nxt = mem_ready ? MEMWB : MEMRD;
      MEMWR:  nxt = mem_ready ? FETCH : MEMWR;
      ADDIEX: nxt = ADDIWB;
      ALUWB, MEMWB, BRANCH, ADDIWB, JUMP: nxt = FETCH;
      default: nxt = ILLEGAL;
    endcase
  end
  always_comb begin
    {mem_req, mem_we, iord, ir_we, pc_we, pc_src, reg_we, reg_dst, mem_to_reg, alu_src_a, alu_src_b, aluctr, illegal} = '0;
    case (state)
      FETCH:   begin mem_req = 1'b1; alu_src_b = 2'b01; ir_we = mem_ready; pc_we = mem_ready; end
      DECODE:  alu_src_b = 2'b11;
      RTYPE:   begin alu_src_a = 1'b1; aluctr = fn_aluctr; end
      ALUWB:   begin reg_we = 1'b1; reg_dst = 1'b1; end
      MEMADR:  begin alu_src_a = 1'b1; alu_src_b = 2'b10; end
      MEMRD:   begin mem_req = 1'b1; iord = 1'b1; end
      MEMWB:   begin reg_we = 1'b1; mem_to_reg = 1'b1; end
      MEMWR:   begin mem_req = 1'b1; mem_we = 1'b1; iord = 1'b1; end
      BRANCH:  begin alu_src_a = 1'b1; aluctr = ALU_SUB; pc_src = 2'b01; pc_we = zero; end
      ADDIEX:  begin alu_src_a = 1'b1; alu_src_b = 2'b10; end
      ADDIWB:  reg_we = 1'b1;
      JUMP:    begin pc_src = 2'b10; pc_we = 1'b1; end
      ILLEGAL: illegal = 1'b1;
      default: illegal = 1'b0;
    endcase
    if (rst) {mem_req, mem_we, iord, ir_we, pc_we, pc_src, reg_we, reg_dst, mem_to_reg, alu_src_a, alu_src_b, aluctr, illegal} = '0;
  end
endmodule
